// File: rtl/rstgen_seq_if.sv
// CSR bus bundle for rstgen_seq: the address, write strobe and write data come
// from the bus master; the registered read data goes back to it.
interface rstgen_seq_if;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;

   modport master (output csr_a, output csr_we, output csr_di, input csr_do);
   modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/rstgen_seq.sv
// Sequenced reset controller: debounces the reset sources, then releases the
// reset domains one by one in index order. Software can request a full reset,
// hold individual domains, read the reset cause and count re-entries to HOLD.
//
// state   | meaning
// --------+---------------------------------------------------------------
// HOLD    | all domains held, debounce counter running down to zero
// RELEASE | domains being released one per release_gap cycles
// RUN     | all domains released by the sequencer, waiting for a trigger
module rstgen_seq #(
   parameter logic [3:0] csr_addr    = 4'h2,
   parameter int         ndomains    = 4,
   parameter int         debounce_w  = 20,
   parameter int         release_gap = 16,
   parameter int         sync_stages = 2
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                resetin,
   input  logic                hard_reset_i,
   rstgen_seq_if.slave         csr,
   output logic [ndomains-1:0] rst_o,
   output logic                rst_done_o
);
   localparam int idx_w = (ndomains > 1) ? $clog2(ndomains) : 1;
   localparam int gap_w = (release_gap > 1) ? $clog2(release_gap) : 1;
   localparam logic [gap_w-1:0] gap_reload = gap_w'(release_gap - 1);

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [sync_stages-1:0] sync_q, sync_d;
   logic [debounce_w-1:0]  deb_q, deb_d;
   logic [gap_w-1:0]       gap_q, gap_d;
   logic [idx_w-1:0]       idx_q, idx_d;
   logic [ndomains-1:0]    seq_q, seq_d;
   logic [ndomains-1:0]    mask_q, mask_d;
   logic [ndomains-1:0]    rst_q, rst_d;
   logic                   done_q, done_d;
   logic [3:0]             cause_q, cause_d;
   logic [15:0]            count_q, count_d;
   logic [31:0]            do_q, do_d;

   logic btn_s, sel, wr0, wr1, sw_req, trig;
   logic unused_csr;

   assign unused_csr = ^{csr.csr_di[31:8+ndomains], csr.csr_di[7:4], csr.csr_a[9:2]};

   // Synchroniser on the button and CSR write decode; all trigger sources merge here
   always_comb begin
      sync_d = {sync_q[sync_stages-2:0], resetin};
      btn_s  = sync_q[sync_stages-1];
      sel    = (csr.csr_a[13:10] == csr_addr);
      wr0    = sel & csr.csr_we & (csr.csr_a[1:0] == 2'd0);
      wr1    = sel & csr.csr_we & (csr.csr_a[1:0] == 2'd1);
      sw_req = wr0 & csr.csr_di[0];
      trig   = btn_s | hard_reset_i | sw_req;
   end

   // Sequencer next state: any trigger restarts the debounce hold from scratch
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      seq_d   = seq_q;
      done_d  = done_q;
      count_d = count_q;
      if (trig) begin
         state_d = HOLD;
         deb_d   = '1;
         seq_d   = '1;
         done_d  = 1'b0;
         if (state_q != HOLD && count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end else begin
         case (state_q)
            HOLD: begin
               if (deb_q == '0) begin
                  seq_d[0] = 1'b0;
                  gap_d    = gap_reload;
                  idx_d    = idx_w'(1);
                  if (ndomains == 1) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
                  deb_d = deb_q - debounce_w'(1);
               end
            end
            RELEASE: begin
               if (gap_q == '0) begin
                  seq_d[idx_q] = 1'b0;
                  gap_d        = gap_reload;
                  if (int'(idx_q) == ndomains - 1) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     idx_d = idx_q + idx_w'(1);
                  end
               end else begin
                  gap_d = gap_q - gap_w'(1);
               end
            end
            RUN: ;
            default: state_d = HOLD;
         endcase
      end
   end

   // CSR side: mask, sticky cause with set-over-clear, registered read mux
   always_comb begin
      mask_d  = wr0 ? csr.csr_di[8 +: ndomains] : mask_q;
      cause_d = (cause_q & ~(wr1 ? csr.csr_di[3:0] : 4'h0))
              | {sw_req, hard_reset_i, btn_s, 1'b0};
      rst_d   = seq_d | mask_d;
      do_d    = '0;
      if (sel) begin
         case (csr.csr_a[1:0])
            2'd0: begin
               do_d[8 +: ndomains] = mask_q;
               do_d[1:0]           = state_q;
            end
            2'd1:    do_d[3:0]  = cause_q;
            2'd2:    do_d[15:0] = count_q;
            default: do_d       = '0;
         endcase
      end
   end

   // State registers; power-on reset holds every domain and records POR
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= HOLD;
         sync_q  <= '0;
         deb_q   <= '1;
         gap_q   <= '0;
         idx_q   <= '0;
         seq_q   <= '1;
         mask_q  <= '0;
         rst_q   <= '1;
         done_q  <= 1'b0;
         cause_q <= 4'b0001;
         count_q <= '0;
         do_q    <= '0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         deb_q   <= deb_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         seq_q   <= seq_d;
         mask_q  <= mask_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         cause_q <= cause_d;
         count_q <= count_d;
         do_q    <= do_d;
      end
   end

   assign rst_o      = rst_q;
   assign rst_done_o = done_q;
   assign csr.csr_do = do_q;
endmodule

// File: doc/rstgen_seq.md
Name: rstgen_seq

Overview:
CSR-mapped, parametrised reset controller that produces sequenced resets for ndomains reset domains. It generalises the single-output synchroniser/debouncer with a power-on and hard reset used in our SoC tops. It adds ordered per-domain release, a software full-reset trigger, per-domain software hold masks, a reset-cause register and a reset counter. It sits beside sysctl on the CSR bus and drives the reset inputs of CPU, bus and peripherals.

Parameters:
csr_addr, 4'h2, CSR page; the block is selected when csr_a[13:10]==csr_addr
ndomains, 4, number of reset domains (1..16)
debounce_w, 20, debounce counter width; hold time is 2^debounce_w-1 cycles
release_gap, 16, cycles between successive domain releases (>=1)
sync_stages, 2, synchroniser flops on resetin (>=2)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset (power-on)
resetin  in  1  external reset button, active high, asynchronous
hard_reset_i  in  1  one-cycle hard reset request from sysctl, sys_clk domain
csr_a  in  14  CSR address
csr_we  in  1  CSR write strobe
csr_di  in  32  CSR write data
csr_do  out  32  CSR read data, registered; 0 when the block is not selected (OR-combined bus)
rst_o  out  ndomains  active-high domain resets, registered, synchronous deassert
rst_done_o  out  1  high once all domains are released by the sequencer

Behaviour:
- Reset values (sys_rst_n low): state=HOLD, debounce counter all ones, rst_o all ones, rst_done_o=0, cause=4'b0001 (POR), count=0, mask=0, csr_do=0.
- resetin passes through sync_stages flops, giving btn_s.
- trig = btn_s | hard_reset_i | sw_req. sw_req is a one-cycle pulse on a write to reg0 with bit0=1.
- On a trig cycle, at that edge: counter<=all ones; state<=HOLD; the sequencer reset vector goes to all ones; rst_done_o<=0.
- HOLD:
  - Counter decrements each cycle without trig.
  - At the edge where the counter==0 and there is no trig: state<=RELEASE, rst_o[0] deasserts, gap counter<=release_gap-1.
- RELEASE:
  - Gap counter decrements; at 0, the next domain index releases and the gap counter reloads.
  - Domain k deasserts exactly k*release_gap cycles after domain 0.
  - The edge that releases domain ndomains-1 also sets state<=RUN and rst_done_o<=1.
  - ndomains=1 goes directly HOLD->RUN.
- RUN: stays until trig.
- trig in RELEASE or RUN aborts to HOLD immediately, asserting all rst_o at the next edge.
- rst_o = seq_rst | mask, registered. mask holds individual domains in any state and does not affect rst_done_o or the FSM.
- cause[3:0] = {SW, HARD, BUTTON, POR}, sticky.
  - Set when the corresponding trig source is active; btn_s sets BUTTON each cycle it is high.
  - Write-1-to-clear via reg1. A set in the same cycle wins over the clear.
- count: 16 bits. Increments on each HOLD entry from RELEASE or RUN. Retrigger inside HOLD does not count. Saturates at 16'hFFFF.
- Continuous resetin high keeps HOLD with the counter reloaded; count increments once.
- CSR map, register index csr_a[1:0]:
  - reg0: write bit0 = sw full reset (self-clearing) and bits[8+ndomains-1:8] = mask. Read {mask at [8+:ndomains], state at [1:0]} with HOLD=0, RELEASE=1, RUN=2.
  - reg1: cause, W1C.
  - reg2: count, read-only.
  - reg3: reads 0.
- csr_do is updated one cycle after csr_a; 0 when not selected.
- sw reset and hard reset do not clear mask, cause or count. Only sys_rst_n clears them.

Test Plan:
Use debounce_w=4, release_gap=3, ndomains=4, sync_stages=2.
1. Deassert sys_rst_n -> rst_o=4'hF for 15 edges; rst_o[0] drops at edge 15, [1] at 18, [2] at 21, [3] at 24 with rst_done_o=1 the same edge; reg1 reads 0x1, reg2 reads 0.
2. In RUN, 1-cycle resetin pulse -> 2 cycles later rst_o=4'hF and rst_done_o=0 at the next edge; full sequence repeats; reg1=0x3, reg2=1.
3. Abort mid-RELEASE (after domain 1 released) via hard_reset_i -> all rst_o high at the next edge, counter reloaded; reg1 bit2 set, reg2 incremented.
4. In RUN, write reg0=0x400 -> rst_o=4'b0100 after one edge, rst_done_o stays 1, state reads 2; write 0 -> rst_o=0.
5. Write reg1=0xF in the same cycle as hard_reset_i -> reg1 reads 0x4. Hold resetin high 100 cycles -> reg2 increments by exactly 1; release occurs 15 cycles after the last synced-high cycle.
6. Read with csr_a[13:10]!=csr_addr -> csr_do=0. Write reg0 bit0=1 -> HOLD next edge, cause bit3 set, mask unchanged.
